// File: rtl/req_gnt_pkg.sv
// rtl/req_gnt_pkg.sv - shared types and helpers for the req/gnt delay generator
// Purpose: pipe entry type and count-width helper.
// Contents:
//   RG_ID_W     default request/grant ID width
//   rg_entry_t  one pipe stage: {vld, id}
//   rg_cnt_w()  width needed to count 0..max_out
package req_gnt_pkg;

  localparam int RG_ID_W = 4;

  typedef struct packed {
    logic               vld;
    logic [RG_ID_W-1:0] id;
  } rg_entry_t;

  function automatic int rg_cnt_w(input int max_out);
    return (max_out < 1) ? 1 : $clog2(max_out + 1);
  endfunction

endpackage

// File: rtl/rg_delay_pipe.sv
// rtl/rg_delay_pipe.sv - fixed-latency shift register of rg_entry_t
// Purpose: delays each entry by exactly DEPTH clocks, never reordering.
// Ports:
//   clk      in   clock, posedge
//   rst_n    in   async active-low reset, clears every stage
//   i_entry  in   entry loaded into stage 0 every edge
//   o_entry  out  registered content of the last stage
module rg_delay_pipe
  import req_gnt_pkg::*;
#(
  parameter int DEPTH = 3
) (
  input  logic      clk,
  input  logic      rst_n,
  input  rg_entry_t i_entry,
  output rg_entry_t o_entry
);

  rg_entry_t r_stage [DEPTH];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) begin
        r_stage[i] <= '0;
      end
    end else begin
      r_stage[0] <= i_entry;
      for (int i = 1; i < DEPTH; i++) begin
        r_stage[i] <= r_stage[i-1];
      end
    end
  end

  assign o_entry = r_stage[DEPTH-1];

endmodule

// File: rtl/req_gnt_delay_gen.sv
// rtl/req_gnt_delay_gen.sv - fixed-latency grant generator with intake throttling
// Purpose: each accepted request returns a one-cycle grant GNT_DELAY clocks
//   later carrying the request ID; in-flight count is limited to MAX_OUT and
//   rejected requests are counted in a saturating counter.
// Ports:
//   clk          in   clock, posedge
//   rst_n        in   async active-low reset
//   req          in   request, sampled at posedge clk
//   req_id       in   ID qualified by req
//   req_rdy      out  combinational: a req this cycle is accepted
//   gnt          out  registered grant pulse
//   gnt_id       out  ID of the granted request, 0 when gnt=0
//   outstanding  out  number of in-flight requests
//   drop_cnt     out  saturating count of rejected requests
//   busy         out  outstanding != 0
// Build option: define RGD_SVA_EN to embed protocol assertions.
module req_gnt_delay_gen
  import req_gnt_pkg::*;
#(
  parameter int GNT_DELAY = 3,
  parameter int MAX_OUT   = 3,
  parameter int ID_W      = RG_ID_W,
  parameter int DROP_W    = 8
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic                          req,
  input  logic [ID_W-1:0]               req_id,
  output logic                          req_rdy,
  output logic                          gnt,
  output logic [ID_W-1:0]               gnt_id,
  output logic [rg_cnt_w(MAX_OUT)-1:0]  outstanding,
  output logic [DROP_W-1:0]             drop_cnt,
  output logic                          busy
);

  localparam int CNT_W = rg_cnt_w(MAX_OUT);
  // With as many slots as pipe stages the pipe itself is the limit, so
  // intake can never be blocked.
  localparam bit NEVER_FULL = (MAX_OUT >= GNT_DELAY);

  rg_entry_t          w_in_entry;
  rg_entry_t          w_out_entry;
  logic               w_retire;
  logic               w_accept;
  logic               w_drop;
  logic [CNT_W-1:0]   r_outstanding;
  logic [DROP_W-1:0]  r_drop_cnt;

  assign w_retire = w_out_entry.vld;

  // A retiring grant frees its slot in the same cycle it leaves.
  generate
    if (NEVER_FULL) begin : g_rdy_const
      assign req_rdy = 1'b1;
    end else begin : g_rdy_limit
      assign req_rdy = (r_outstanding < CNT_W'(MAX_OUT)) || w_retire;
    end
  endgenerate

  assign w_accept = req && req_rdy;
  assign w_drop   = req && !req_rdy;

  // Unaccepted cycles push an empty bubble; the ID is not stored.
  assign w_in_entry.vld = w_accept;
  assign w_in_entry.id  = w_accept ? req_id : '0;

  rg_delay_pipe #(
    .DEPTH (GNT_DELAY)
  ) u_pipe (
    .clk     (clk),
    .rst_n   (rst_n),
    .i_entry (w_in_entry),
    .o_entry (w_out_entry)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_outstanding <= '0;
      r_drop_cnt    <= '0;
    end else begin
      case ({w_accept, w_retire})
        2'b10:   r_outstanding <= r_outstanding + 1'b1;
        2'b01:   r_outstanding <= r_outstanding - 1'b1;
        default: r_outstanding <= r_outstanding;
      endcase
      if (w_drop && (r_drop_cnt != '1)) begin
        r_drop_cnt <= r_drop_cnt + 1'b1;
      end
    end
  end

  assign gnt         = w_out_entry.vld;
  assign gnt_id      = w_out_entry.id;
  assign outstanding = r_outstanding;
  assign drop_cnt    = r_drop_cnt;
  assign busy        = (r_outstanding != '0);

`ifdef RGD_SVA_EN
  property p_accept_gets_gnt;
    @(posedge clk) disable iff (!rst_n)
      (req && req_rdy) |-> ##GNT_DELAY (gnt && gnt_id == $past(req_id, GNT_DELAY));
  endproperty

  property p_gnt_has_accept;
    @(posedge clk) disable iff (!rst_n)
      gnt |-> $past(req && req_rdy, GNT_DELAY);
  endproperty

  property p_outstanding_limit;
    @(posedge clk) disable iff (!rst_n)
      outstanding <= CNT_W'(MAX_OUT);
  endproperty

  a_accept_gets_gnt: assert property (p_accept_gets_gnt)
    else $error("accepted request did not receive its grant");
  a_gnt_has_accept: assert property (p_gnt_has_accept)
    else $error("grant without a matching accepted request");
  a_outstanding_limit: assert property (p_outstanding_limit)
    else $error("outstanding exceeds MAX_OUT");
`endif

endmodule

// File: tb/tb_req_gnt_delay_gen.sv
// tb/tb_req_gnt_delay_gen.sv - directed self-checking bench for req_gnt_delay_gen
module tb_req_gnt_delay_gen;

  logic clk;
  logic rst_n;

  // dut_a: GNT_DELAY=3 MAX_OUT=3
  logic       a_req, a_rdy, a_gnt, a_busy;
  logic [3:0] a_id, a_gnt_id;
  logic [1:0] a_out;
  logic [7:0] a_drop;

  // dut_b: GNT_DELAY=3 MAX_OUT=2
  logic       b_req, b_rdy, b_gnt, b_busy;
  logic [3:0] b_id, b_gnt_id;
  logic [1:0] b_out;
  logic [7:0] b_drop;

  // dut_c: GNT_DELAY=3 MAX_OUT=1 DROP_W=2
  logic       c_req, c_rdy, c_gnt, c_busy;
  logic [3:0] c_id, c_gnt_id;
  logic [0:0] c_out;
  logic [1:0] c_drop;

  int total;
  int bad;

  req_gnt_delay_gen #(.GNT_DELAY(3), .MAX_OUT(3), .ID_W(4), .DROP_W(8)) dut_a (
    .clk(clk), .rst_n(rst_n), .req(a_req), .req_id(a_id), .req_rdy(a_rdy),
    .gnt(a_gnt), .gnt_id(a_gnt_id), .outstanding(a_out), .drop_cnt(a_drop), .busy(a_busy)
  );

  req_gnt_delay_gen #(.GNT_DELAY(3), .MAX_OUT(2), .ID_W(4), .DROP_W(8)) dut_b (
    .clk(clk), .rst_n(rst_n), .req(b_req), .req_id(b_id), .req_rdy(b_rdy),
    .gnt(b_gnt), .gnt_id(b_gnt_id), .outstanding(b_out), .drop_cnt(b_drop), .busy(b_busy)
  );

  req_gnt_delay_gen #(.GNT_DELAY(3), .MAX_OUT(1), .ID_W(4), .DROP_W(2)) dut_c (
    .clk(clk), .rst_n(rst_n), .req(c_req), .req_id(c_id), .req_rdy(c_rdy),
    .gnt(c_gnt), .gnt_id(c_gnt_id), .outstanding(c_out), .drop_cnt(c_drop), .busy(c_busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Each loop iteration: drive just after a posedge, check at the following
  // negedge (values seen by edge e), then advance to edge e.

  task automatic test_reset;
    rst_n = 1'b0;
    a_req = 0; a_id = 0; b_req = 0; b_id = 0; c_req = 0; c_id = 0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    total++; if (a_gnt !== 1'b0 || a_gnt_id !== 4'd0) begin bad++; $display("FAIL reset_gnt: got %0b/%0d want 0/0", a_gnt, a_gnt_id); end
    total++; if (a_out !== 2'd0 || a_busy !== 1'b0) begin bad++; $display("FAIL reset_out: got %0d/%0b want 0/0", a_out, a_busy); end
    total++; if (a_drop !== 8'd0 || b_drop !== 8'd0 || c_drop !== 2'd0) begin bad++; $display("FAIL reset_drop: got %0d/%0d/%0d want 0", a_drop, b_drop, c_drop); end
    total++; if (a_rdy !== 1'b1 || b_rdy !== 1'b1 || c_rdy !== 1'b1) begin bad++; $display("FAIL reset_rdy: got %0b%0b%0b want 111", a_rdy, b_rdy, c_rdy); end
    total++; if (b_gnt !== 1'b0 || c_gnt !== 1'b0 || b_out !== 2'd0 || c_out !== 1'd0) begin bad++; $display("FAIL reset_bc: gnt %0b%0b out %0d/%0d want 0", b_gnt, c_gnt, b_out, c_out); end
    @(posedge clk); #1;
    rst_n = 1'b1;
  endtask

  task automatic test_single;
    int exp_out [6] = '{0, 1, 1, 1, 0, 0};
    for (int e = 1; e <= 6; e++) begin
      a_req = (e == 1); a_id = (e == 1) ? 4'd5 : 4'd0;
      @(negedge clk);
      total++; if (a_gnt !== (e == 4)) begin bad++; $display("FAIL single_gnt e%0d: got %0b want %0b", e, a_gnt, (e == 4)); end
      total++; if (a_gnt_id !== ((e == 4) ? 4'd5 : 4'd0)) begin bad++; $display("FAIL single_id e%0d: got %0d want %0d", e, a_gnt_id, (e == 4) ? 5 : 0); end
      total++; if (a_out !== 2'(exp_out[e-1])) begin bad++; $display("FAIL single_out e%0d: got %0d want %0d", e, a_out, exp_out[e-1]); end
      total++; if (a_busy !== (exp_out[e-1] != 0)) begin bad++; $display("FAIL single_busy e%0d: got %0b want %0b", e, a_busy, (exp_out[e-1] != 0)); end
      @(posedge clk); #1;
    end
    a_req = 0;
  endtask

  task automatic test_back_to_back;
    for (int e = 1; e <= 7; e++) begin
      a_req = (e <= 3); a_id = (e <= 3) ? 4'(e) : 4'd0;
      @(negedge clk);
      total++; if (a_rdy !== 1'b1) begin bad++; $display("FAIL b2b_rdy e%0d: got %0b want 1", e, a_rdy); end
      total++; if (a_gnt !== (e >= 4 && e <= 6)) begin bad++; $display("FAIL b2b_gnt e%0d: got %0b want %0b", e, a_gnt, (e >= 4 && e <= 6)); end
      total++; if (a_gnt_id !== ((e >= 4 && e <= 6) ? 4'(e - 3) : 4'd0)) begin bad++; $display("FAIL b2b_id e%0d: got %0d want %0d", e, a_gnt_id, (e >= 4 && e <= 6) ? e - 3 : 0); end
      @(posedge clk); #1;
    end
    a_req = 0;
    @(negedge clk);
    total++; if (a_drop !== 8'd0 || a_out !== 2'd0) begin bad++; $display("FAIL b2b_end: drop %0d out %0d want 0/0", a_drop, a_out); end
    @(posedge clk); #1;
  endtask

  task automatic test_limit_drop;
    int grants = 0;
    for (int e = 1; e <= 8; e++) begin
      b_req = (e <= 3); b_id = (e <= 3) ? 4'(e) : 4'd0;
      @(negedge clk);
      if (e <= 3) begin
        total++; if (b_rdy !== (e != 3)) begin bad++; $display("FAIL lim_rdy e%0d: got %0b want %0b", e, b_rdy, (e != 3)); end
      end
      total++; if (b_gnt !== (e == 4 || e == 5)) begin bad++; $display("FAIL lim_gnt e%0d: got %0b want %0b", e, b_gnt, (e == 4 || e == 5)); end
      if (b_gnt) begin
        grants++;
        total++; if (b_gnt_id !== 4'(e - 3)) begin bad++; $display("FAIL lim_id e%0d: got %0d want %0d", e, b_gnt_id, e - 3); end
      end
      if (e == 4) begin
        total++; if (b_drop !== 8'd1) begin bad++; $display("FAIL lim_drop: got %0d want 1", b_drop); end
      end
      @(posedge clk); #1;
    end
    b_req = 0;
    total++; if (grants != 2) begin bad++; $display("FAIL lim_grants: got %0d want 2", grants); end
    total++; if (b_out !== 2'd0) begin bad++; $display("FAIL lim_out: got %0d want 0", b_out); end
  endtask

  task automatic test_steady;
    for (int e = 1; e <= 12; e++) begin
      b_req = 1'b1; b_id = 4'(e);
      @(negedge clk);
      total++; if (b_rdy !== ((e % 3) != 0)) begin bad++; $display("FAIL steady_rdy e%0d: got %0b want %0b", e, b_rdy, ((e % 3) != 0)); end
      total++; if (b_gnt !== (e > 3 && ((e - 3) % 3) != 0)) begin bad++; $display("FAIL steady_gnt e%0d: got %0b want %0b", e, b_gnt, (e > 3 && ((e - 3) % 3) != 0)); end
      if (e > 3 && ((e - 3) % 3) != 0) begin
        total++; if (b_gnt_id !== 4'(e - 3)) begin bad++; $display("FAIL steady_id e%0d: got %0d want %0d", e, b_gnt_id, e - 3); end
      end
      @(posedge clk); #1;
    end
    b_req = 0;
    @(negedge clk);
    total++; if (b_drop !== 8'd5) begin bad++; $display("FAIL steady_drop: got %0d want 5", b_drop); end
    @(posedge clk); #1;
  endtask

  task automatic test_reset_midflight;
    for (int e = 1; e <= 6; e++) begin
      a_req = (e == 1); a_id = (e == 1) ? 4'd7 : 4'd0;
      if (e == 3) begin
        rst_n = 1'b0;
        #2;
        rst_n = 1'b1;
      end
      @(negedge clk);
      if (e == 2) begin
        total++; if (a_out !== 2'd1) begin bad++; $display("FAIL midrst_pre_out: got %0d want 1", a_out); end
      end
      total++; if (a_gnt !== 1'b0) begin bad++; $display("FAIL midrst_gnt e%0d: got %0b want 0", e, a_gnt); end
      if (e >= 3) begin
        total++; if (a_out !== 2'd0 || a_drop !== 8'd0) begin bad++; $display("FAIL midrst_cnt e%0d: out %0d drop %0d want 0/0", e, a_out, a_drop); end
      end
      @(posedge clk); #1;
    end
    a_req = 0;
  endtask

  task automatic test_drop_saturate;
    int exp_rdy  [8] = '{1, 0, 0, 1, 0, 0, 1, 0};
    int exp_drop [8] = '{0, 0, 1, 2, 2, 3, 3, 3};
    for (int e = 1; e <= 8; e++) begin
      c_req = 1'b1; c_id = 4'(e);
      @(negedge clk);
      total++; if (c_rdy !== 1'(exp_rdy[e-1])) begin bad++; $display("FAIL sat_rdy e%0d: got %0b want %0d", e, c_rdy, exp_rdy[e-1]); end
      total++; if (c_drop !== 2'(exp_drop[e-1])) begin bad++; $display("FAIL sat_drop e%0d: got %0d want %0d", e, c_drop, exp_drop[e-1]); end
      @(posedge clk); #1;
    end
    c_req = 0;
    @(negedge clk);
    total++; if (c_drop !== 2'd3) begin bad++; $display("FAIL sat_final: got %0d want 3", c_drop); end
    @(posedge clk); #1;
  endtask

  initial begin
    total = 0;
    bad   = 0;
    test_reset();
    test_single();
    test_back_to_back();
    test_limit_drop();
    test_steady();
    test_reset_midflight();
    test_drop_saturate();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
